// File: rtl/mmio_uart_tx_pkg.sv
// Register offsets and transmitter state encoding shared by the UART TX block and its users.
package pkg_parameters;
    localparam logic [3:0] UART_TXDATA_OFS = 4'h0;
    localparam logic [3:0] UART_STATUS_OFS = 4'h4;
    localparam logic [3:0] UART_CTRL_OFS   = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, head entry presented combinationally on dout.
// Latency: a pushed entry is visible on dout the cycle after the push.
// Backpressure: push on full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one the pop frees this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and level interrupt.
// Latency: bus ack one cycle after request; TXDATA write into idle block drives start bit two cycles later.
// Backpressure: none on the bus (zero wait states); writes to a full FIFO are dropped and flagged in overflow.
module mmio_uart_tx
    import pkg_parameters::*;
#(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

    uart_tx_state_t state;
    logic [15:0]    baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           tx_en;
    logic           irq_en;
    logic           overflow;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic [3:0]     reg_ofs;
    logic           busy;
    logic           bit_end;
    logic           wr_txdata;
    logic           wr_status;
    logic           wr_ctrl;
    logic [31:0]    rd_mux;
    logic           unused_bits;

    assign reg_ofs   = {addr_i[3:2], 2'b00};
    assign wr_txdata = req_i && we_i && (reg_ofs == UART_TXDATA_OFS);
    assign wr_status = req_i && we_i && (reg_ofs == UART_STATUS_OFS);
    assign wr_ctrl   = req_i && we_i && (reg_ofs == UART_CTRL_OFS);
    assign busy      = (state != ST_IDLE);
    assign bit_end   = (baud_cnt == 16'd0);
    // A new byte is taken either from idle or straight out of a finishing stop bit.
    assign fifo_pop  = tx_en && !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
    assign fifo_push = wr_txdata;
    assign unused_bits = ^{wdata_i[31:8], addr_i[1:0]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wdata_i[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rd_mux = '0;
        case (reg_ofs)
            UART_STATUS_OFS: rd_mux = {24'd0, 4'(fifo_count), overflow, busy, fifo_empty, fifo_full};
            UART_CTRL_OFS:   rd_mux = {30'd0, irq_en, tx_en};
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o    <= 1'b0;
            rdata_o  <= '0;
            tx_en    <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            ack_o   <= req_i;
            rdata_o <= (req_i && !we_i) ? rd_mux : '0;
            if (wr_ctrl) begin
                tx_en  <= wdata_i[0];
                irq_en <= wdata_i[1];
            end
            if (wr_txdata && fifo_full && !fifo_pop)
                overflow <= 1'b1;
            else if (wr_status && wdata_i[3])
                overflow <= 1'b0;
            irq_o <= irq_en && fifo_empty && !busy;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_o     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state    <= ST_START;
                        baud_cnt <= BAUD_RELOAD;
                        shreg    <= fifo_dout;
                        tx_o     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state    <= ST_DATA;
                        baud_cnt <= BAUD_RELOAD;
                        bit_idx  <= '0;
                        tx_o     <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_o    <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (fifo_pop) begin
                            state    <= ST_START;
                            baud_cnt <= BAUD_RELOAD;
                            shreg    <= fifo_dout;
                            tx_o     <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus transactions, serial-line decoder and byte scoreboard.
module tb_mmio_uart_tx;
    import pkg_parameters::*;

    localparam int BD = 4;
    localparam int FR = 10 * BD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        tx;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         fs_q[$];

    mmio_uart_tx #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .ack_o   (ack),
        .tx_o    (tx),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = 1'b1;
        addr  = a | 4'($urandom_range(0, 3));
        wdata = d;
        step(1);
        req   = 1'b0;
        we    = 1'b0;
        wdata = $urandom();
        chk("wr_ack", 32'(ack), 32'h1);
        chk("wr_rdata", rdata, 32'h0);
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        req  = 1'b1;
        we   = 1'b0;
        addr = a | 4'($urandom_range(0, 3));
        step(1);
        req  = 1'b0;
        chk("rd_ack", 32'(ack), 32'h1);
        d = rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        chk("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic check_bytes();
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            if (rx_q.size() > 0) chk("rx_byte", 32'(rx_q.pop_front()), 32'(e));
        end
        rx_q.delete();
    endtask

    task automatic count_low(input string tag, input int n);
        int lows = 0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1) lows++;
            step(1);
        end
        chk(tag, 32'(lows), 32'h0);
    endtask

    // Line decoder: samples the middle of each bit period after a falling start edge.
    initial begin : rx_mon
        int ph;
        int t;
        int b;
        logic [7:0] sh;
        ph = 0;
        sh = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                ph = 0;
            end else if (ph == 0) begin
                if (tx === 1'b0) begin
                    ph = 1;
                    fs_q.push_back(cyc);
                end
            end else begin
                ph++;
                t = ph - 1;
                if (t % BD == BD / 2) begin
                    b = t / BD;
                    if (b == 0) begin
                        chk("start_bit", 32'(tx), 32'h0);
                    end else if (b <= 8) begin
                        sh[b-1] = tx;
                    end else begin
                        chk("stop_bit", 32'(tx), 32'h1);
                        rx_q.push_back(sh);
                        ph = 0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  pat;
        logic [7:0]  b8;
        logic [31:0] d;
        int          cur;
        int          n;
        int          mcount;
        logic        movf;
        logic        ie;

        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        rd_chk("rst_status", UART_STATUS_OFS, 32'h2);
        rd_chk("rst_ctrl", UART_CTRL_OFS, 32'h0);
        step(1);
        chk("ack_idle", 32'(ack), 32'h0);
        chk("rdata_idle", rdata, 32'h0);

        // Single frame 0x55: latency, bit timing, busy fall.
        bus_wr(UART_CTRL_OFS, 32'h1);
        bus_wr(UART_TXDATA_OFS, 32'h55);
        exp_q.push_back(8'h55);
        chk("lat_n1", 32'(tx), 32'h1);
        step(1);
        chk("lat_n2", 32'(tx), 32'h0);
        cur = 2;
        pat = 8'h55;
        for (int k = 0; k < 8; k++) begin
            step(7 + 4 * k - cur);
            cur = 7 + 4 * k;
            chk("data_bit", 32'(tx), 32'(pat[k]));
        end
        step(39 - cur);
        chk("stop_level", 32'(tx), 32'h1);
        step(2);
        rd_chk("busy_n41", UART_STATUS_OFS, 32'h6);
        rd_chk("busy_n42", UART_STATUS_OFS, 32'h2);
        wait_rx(1, 20);
        check_bytes();

        // Fill with transmitter disabled, overflow, sticky clear.
        bus_wr(UART_CTRL_OFS, 32'h0);
        for (int i = 0; i < 9; i++) begin
            d = $urandom();
            if (i < 8) exp_q.push_back(d[7:0]);
            bus_wr(UART_TXDATA_OFS, d);
        end
        rd_chk("full_ovf", UART_STATUS_OFS, 32'h89);
        bus_wr(UART_STATUS_OFS, 32'h0);
        rd_chk("ovf_keep", UART_STATUS_OFS, 32'h89);
        bus_wr(UART_STATUS_OFS, 32'h8);
        rd_chk("ovf_clear", UART_STATUS_OFS, 32'h81);

        // Enable, and push on full in the same cycle as the first pop.
        fs_q.delete();
        bus_wr(UART_CTRL_OFS, 32'h1);
        bus_wr(UART_TXDATA_OFS, 32'h5A);
        exp_q.push_back(8'h5A);
        wait_rx(9, 9 * FR + 50);
        chk("b2b_frames", 32'(fs_q.size()), 32'd9);
        if (fs_q.size() >= 9)
            for (int i = 1; i < 9; i++) chk("b2b_gap", 32'(fs_q[i] - fs_q[i-1]), 32'(FR));
        check_bytes();
        step(5);
        rd_chk("drained", UART_STATUS_OFS, 32'h2);

        // Interrupt behaviour around one frame.
        bus_wr(UART_CTRL_OFS, 32'h3);
        step(1);
        chk("irq_idle", 32'(irq), 32'h1);
        bus_wr(UART_TXDATA_OFS, 32'hA3);
        exp_q.push_back(8'hA3);
        chk("irq_n1", 32'(irq), 32'h1);
        step(1);
        n = 0;
        for (int i = 2; i <= 42; i++) begin
            if (irq !== 1'b0) n++;
            step(1);
        end
        chk("irq_frame", 32'(n), 32'h0);
        chk("irq_n43", 32'(irq), 32'h1);
        bus_wr(UART_CTRL_OFS, 32'h1);
        step(1);
        chk("irq_off", 32'(irq), 32'h0);
        wait_rx(1, 10);
        check_bytes();

        // Reset in the middle of a frame.
        bus_wr(UART_TXDATA_OFS, 32'h0F);
        step(18);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'h1);
        chk("mid_rst_ack", 32'(ack), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        step(2);
        rst_n = 1'b1;
        rd_chk("post_rst_status", UART_STATUS_OFS, 32'h2);
        rd_chk("post_rst_ctrl", UART_CTRL_OFS, 32'h0);
        count_low("post_rst_line", 60);
        bus_wr(UART_CTRL_OFS, 32'h1);
        count_low("post_rst_en_line", 30);
        chk("post_rst_rx", 32'(rx_q.size()), 32'h0);

        // Back-to-back reads.
        rd_chk("b2b_status", UART_STATUS_OFS, 32'h2);
        rd_chk("b2b_ctrl", UART_CTRL_OFS, 32'h1);
        rd_chk("b2b_c", 4'hC, 32'h0);
        rd_chk("b2b_txdata", UART_TXDATA_OFS, 32'h0);
        step(1);
        chk("b2b_ack_end", 32'(ack), 32'h0);
        chk("b2b_rdata_end", rdata, 32'h0);

        // Random fills with transmitter off, then drain.
        for (int it = 0; it < 6; it++) begin
            bus_wr(UART_CTRL_OFS, 32'h0);
            n = $urandom_range(1, 12);
            mcount = 0;
            movf = 1'b0;
            for (int i = 0; i < n; i++) begin
                d = $urandom();
                if (mcount < 8) begin
                    exp_q.push_back(d[7:0]);
                    mcount++;
                end else begin
                    movf = 1'b1;
                end
                bus_wr(UART_TXDATA_OFS, d);
                step($urandom_range(0, 2));
            end
            rd_chk("rand_status", UART_STATUS_OFS,
                   {24'd0, 4'(mcount), movf, 1'b0, 1'b0, (mcount == 8)});
            bus_wr(UART_STATUS_OFS, 32'h8);
            ie = 1'($urandom_range(0, 1));
            bus_wr(UART_CTRL_OFS, {30'd0, ie, 1'b1});
            wait_rx(mcount, mcount * FR + 100);
            check_bytes();
            step(5);
            rd_chk("rand_done", UART_STATUS_OFS, 32'h2);
            chk("rand_irq", 32'(irq), 32'(ie));
        end

        // Random writes with transmitter running.
        for (int it = 0; it < 3; it++) begin
            bus_wr(UART_CTRL_OFS, 32'h1);
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                b8 = 8'($urandom());
                exp_q.push_back(b8);
                bus_wr(UART_TXDATA_OFS, {24'($urandom()), b8});
                step($urandom_range(0, 30));
            end
            wait_rx(n, n * FR + 400);
            check_bytes();
            step(5);
            rd_chk("run_done", UART_STATUS_OFS, 32'h2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
